// File: rtl/ref_data_prefetcher.sv
// ref_data_prefetcher
// Captures reference particle positions from the home-cell broadcast stream
// into one prefetch FIFO per phase and presents the head of the active
// phase's FIFO to the force pipeline through a valid/advance handshake.
// Per-phase cell IDs come in as a vector, so one netlist serves every slot.
// The phase and bcast_phase inputs are assumed to stay below NUM_PHASES.
module ref_data_prefetcher #(
  parameter int OFFSET_WIDTH      = 29,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int DATA_WIDTH        = OFFSET_WIDTH + CELL_ID_WIDTH,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NUM_PHASES        = 2,
  parameter int PREFETCH_DEPTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [$clog2(NUM_PHASES)-1:0]         phase,
  input  logic [NUM_PHASES*3*CELL_ID_WIDTH-1:0] cell_ids,
  input  logic                                  count_valid,
  input  logic                                  bcast_valid,
  input  logic [$clog2(NUM_PHASES)-1:0]         bcast_phase,
  input  logic [PARTICLE_ID_WIDTH-1:0]          bcast_id,
  input  logic [OFFSET_WIDTH-1:0]               raw_x,
  input  logic [OFFSET_WIDTH-1:0]               raw_y,
  input  logic [OFFSET_WIDTH-1:0]               raw_z,
  input  logic                                  ref_advance,
  output logic [PARTICLE_ID_WIDTH-1:0]          ref_particle_count,
  output logic                                  ref_valid,
  output logic [PARTICLE_ID_WIDTH-1:0]          ref_id,
  output logic [DATA_WIDTH-1:0]                 ref_x,
  output logic [DATA_WIDTH-1:0]                 ref_y,
  output logic [DATA_WIDTH-1:0]                 ref_z,
  output logic                                  ref_exhausted,
  output logic                                  overflow
);

  localparam int PHASE_W = $clog2(NUM_PHASES);
  localparam int PTR_W   = $clog2(PREFETCH_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int CAP_W   = PARTICLE_ID_WIDTH + 1;
  localparam int CELL_W  = 3 * CELL_ID_WIDTH;

  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(PREFETCH_DEPTH);
  localparam logic [CAP_W-1:0] FIRST_ID = CAP_W'(1);

  // One prefetched reference: particle ID plus assembled {cell id, offset} coordinates.
  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]        x;
    logic [DATA_WIDTH-1:0]        y;
    logic [DATA_WIDTH-1:0]        z;
  } entry_t;

  // Per-phase FIFO storage and bookkeeping.
  entry_t           mem    [NUM_PHASES][PREFETCH_DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_PHASES];
  logic [PTR_W-1:0] wr_ptr [NUM_PHASES];
  logic [OCC_W-1:0] occ    [NUM_PHASES];
  // One bit wider than a particle ID so the pointer can step past a
  // count of 2^PARTICLE_ID_WIDTH-1 without wrapping back to a live ID.
  logic [CAP_W-1:0] cap_id [NUM_PHASES];

  // Next-state values.
  logic [OCC_W-1:0]             occ_nxt [NUM_PHASES];
  logic [PTR_W-1:0]             rd_nxt  [NUM_PHASES];
  logic [PTR_W-1:0]             wr_nxt  [NUM_PHASES];
  logic [CAP_W-1:0]             cap_nxt [NUM_PHASES];
  logic [PARTICLE_ID_WIDTH-1:0] count_nxt;

  // Capture / pop decisions.
  logic [CELL_W-1:0]     bcast_cells;
  entry_t                wr_entry;
  logic                  cap_hit;
  logic                  push_en;
  logic                  pop_en;
  logic                  drop;
  logic [NUM_PHASES-1:0] push_vec;
  logic [NUM_PHASES-1:0] pop_vec;

  // Post-update head of the active phase.
  entry_t head;
  logic   head_valid;
  logic   head_bypass;
  logic   exhausted_nxt;

  // Assemble the broadcast word and classify it as captured, dropped or ignored.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path before any
    // branching; a path that skips an assignment would infer a latch.
    bcast_cells = cell_ids[bcast_phase*CELL_W +: CELL_W];
    wr_entry.id = bcast_id;
    wr_entry.x  = {bcast_cells[0 +: CELL_ID_WIDTH], raw_x};
    wr_entry.y  = {bcast_cells[CELL_ID_WIDTH +: CELL_ID_WIDTH], raw_y};
    wr_entry.z  = {bcast_cells[2*CELL_ID_WIDTH +: CELL_ID_WIDTH], raw_z};

    // A count word overrides everything else in the same cycle.
    cap_hit = !count_valid && bcast_valid
            && ({1'b0, bcast_id} == cap_id[bcast_phase])
            && (cap_id[bcast_phase] <= {1'b0, ref_particle_count});

    // ref_valid can briefly describe the previous phase right after a phase
    // switch, so the pop also requires the selected FIFO to hold something.
    pop_en = !count_valid && ref_advance && ref_valid && (occ[phase] != '0);

    // A full FIFO still accepts the word when its head leaves this cycle.
    push_en = cap_hit && ((occ[bcast_phase] != FULL_OCC)
                          || (pop_en && (phase == bcast_phase)));
    drop    = cap_hit && !push_en;
  end

  // Per-phase next pointers, occupancy and capture pointer.
  always_comb begin
    count_nxt = count_valid ? raw_x[PARTICLE_ID_WIDTH-1:0] : ref_particle_count;
    push_vec  = '0;
    pop_vec   = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      push_vec[p] = push_en && (bcast_phase == PHASE_W'(p));
      pop_vec[p]  = pop_en && (phase == PHASE_W'(p));
      occ_nxt[p]  = occ[p];
      rd_nxt[p]   = rd_ptr[p];
      wr_nxt[p]   = wr_ptr[p];
      cap_nxt[p]  = cap_id[p];
      if (count_valid) begin
        occ_nxt[p] = '0;
        rd_nxt[p]  = '0;
        wr_nxt[p]  = '0;
        cap_nxt[p] = FIRST_ID;
      end else begin
        occ_nxt[p] = occ[p] + OCC_W'(push_vec[p]) - OCC_W'(pop_vec[p]);
        rd_nxt[p]  = rd_ptr[p] + PTR_W'(pop_vec[p]);
        wr_nxt[p]  = wr_ptr[p] + PTR_W'(push_vec[p]);
        cap_nxt[p] = cap_id[p] + CAP_W'(push_vec[p]);
      end
    end
  end

  // Select the post-update head of the active FIFO; bypass the word being written when it becomes the head.
  always_comb begin
    head_valid  = (occ_nxt[phase] != '0);
    head_bypass = push_vec[phase] && (occ[phase] == OCC_W'(pop_vec[phase]));
    head        = head_bypass ? wr_entry : mem[phase][rd_nxt[phase]];
    if (!head_valid) begin
      head = '0;
    end
    exhausted_nxt = (cap_nxt[phase] > {1'b0, count_nxt}) && !head_valid;
  end

  // FIFO bookkeeping, capture pointers, particle count and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    if (rst) begin
      for (int p = 0; p < NUM_PHASES; p++) begin
        occ[p]    <= '0;
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        cap_id[p] <= FIRST_ID;
      end
      ref_particle_count <= '0;
      overflow           <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PHASES; p++) begin
        occ[p]    <= occ_nxt[p];
        rd_ptr[p] <= rd_nxt[p];
        wr_ptr[p] <= wr_nxt[p];
        cap_id[p] <= cap_nxt[p];
      end
      ref_particle_count <= count_nxt;
      if (count_valid) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Write the captured word into its phase's FIFO.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy gates every
    // read, so stale contents are never presented.
    if (push_en) begin
      mem[bcast_phase][wr_ptr[bcast_phase]] <= wr_entry;
    end
  end

  // Registered presentation of the active phase's head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_valid     <= 1'b0;
      ref_id        <= '0;
      ref_x         <= '0;
      ref_y         <= '0;
      ref_z         <= '0;
      ref_exhausted <= 1'b0;
    end else begin
      ref_valid     <= head_valid;
      ref_id        <= head.id;
      ref_x         <= head.x;
      ref_y         <= head.y;
      ref_z         <= head.z;
      ref_exhausted <= exhausted_nxt;
    end
  end

endmodule

// File: tb/tb_ref_data_prefetcher.sv
// tb_ref_data_prefetcher
// Directed stimulus with a per-phase scoreboard: each broadcast expected to
// be captured pushes its entry; a monitor pops and compares on every
// accepted ref_advance. Status outputs are checked directly.
module tb_ref_data_prefetcher;

  localparam int OW    = 29;
  localparam int CW    = 3;
  localparam int DW    = OW + CW;
  localparam int PW    = 7;
  localparam int NP    = 2;
  localparam int DEPTH = 4;
  localparam int EW    = PW + 3 * DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [0:0]        phase;
  logic [NP*3*CW-1:0] cell_ids;
  logic              count_valid;
  logic              bcast_valid;
  logic [0:0]        bcast_phase;
  logic [PW-1:0]     bcast_id;
  logic [OW-1:0]     raw_x;
  logic [OW-1:0]     raw_y;
  logic [OW-1:0]     raw_z;
  logic              ref_advance;
  logic [PW-1:0]     ref_particle_count;
  logic              ref_valid;
  logic [PW-1:0]     ref_id;
  logic [DW-1:0]     ref_x;
  logic [DW-1:0]     ref_y;
  logic [DW-1:0]     ref_z;
  logic              ref_exhausted;
  logic              overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] mon_got;
  logic [EW-1:0] mon_want;
  logic          mon_have;

  ref_data_prefetcher #(
    .OFFSET_WIDTH(OW), .CELL_ID_WIDTH(CW), .DATA_WIDTH(DW),
    .PARTICLE_ID_WIDTH(PW), .NUM_PHASES(NP), .PREFETCH_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .phase(phase), .cell_ids(cell_ids),
    .count_valid(count_valid), .bcast_valid(bcast_valid),
    .bcast_phase(bcast_phase), .bcast_id(bcast_id),
    .raw_x(raw_x), .raw_y(raw_y), .raw_z(raw_z),
    .ref_advance(ref_advance), .ref_particle_count(ref_particle_count),
    .ref_valid(ref_valid), .ref_id(ref_id),
    .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z),
    .ref_exhausted(ref_exhausted), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Hand-chosen cell tables: phase 0 = {2,2,2}, phase 1 = {idz 5, idy 4, idx 1}.
  function automatic logic [CW-1:0] cx(int ph); return (ph == 0) ? 3'd2 : 3'd1; endfunction
  function automatic logic [CW-1:0] cy(int ph); return (ph == 0) ? 3'd2 : 3'd4; endfunction
  function automatic logic [CW-1:0] cz(int ph); return (ph == 0) ? 3'd2 : 3'd5; endfunction

  // Distinct offsets per (phase, id).
  function automatic logic [OW-1:0] rx(int ph, int id); return OW'(id * 4099 + ph * 7 + 100); endfunction
  function automatic logic [OW-1:0] ry(int ph, int id); return OW'(32'h0100_0000 + id * 131 + ph * 3); endfunction
  function automatic logic [OW-1:0] rz(int ph, int id); return OW'(32'h01AB_CDEF - id * 17 - ph); endfunction

  function automatic logic [EW-1:0] exp_entry(int ph, int id);
    return {PW'(id), cx(ph), rx(ph, id), cy(ph), ry(ph, id), cz(ph), rz(ph, id)};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_count(int n);
    count_valid = 1'b1;
    raw_x       = OW'(n);
    exp_q0.delete();
    exp_q1.delete();
    step();
    count_valid = 1'b0;
  endtask

  // One broadcast word; expect_cap says whether it should land in the FIFO.
  task automatic bcast(int ph, int id, bit expect_cap, bit adv);
    bcast_valid = 1'b1;
    bcast_phase = 1'(ph);
    bcast_id    = PW'(id);
    raw_x       = rx(ph, id);
    raw_y       = ry(ph, id);
    raw_z       = rz(ph, id);
    ref_advance = adv;
    if (expect_cap) begin
      if (ph == 0) exp_q0.push_back(exp_entry(ph, id));
      else         exp_q1.push_back(exp_entry(ph, id));
    end
    step();
    bcast_valid = 1'b0;
    ref_advance = 1'b0;
  endtask

  // Hold ref_advance until the active phase runs dry (bounded); the pop count
  // shows there was no bubble and no double pop.
  task automatic drain(int expect_n, string name);
    int n = 0;
    ref_advance = 1'b1;
    while (ref_valid && n < 4 * DEPTH) begin
      step();
      n++;
    end
    ref_advance = 1'b0;
    check({name, "_pops"}, 128'(n), 128'(expect_n));
    check({name, "_valid_after"}, 128'(ref_valid), 128'(0));
  endtask

  // Scoreboard monitor: an accepted advance consumes the presented entry.
  always @(negedge clk) begin
    if (!rst && ref_valid && ref_advance && !count_valid) begin
      mon_got  = {ref_id, ref_x, ref_y, ref_z};
      mon_have = 1'b0;
      mon_want = '0;
      if (phase == 1'b0 && exp_q0.size() != 0) begin
        mon_want = exp_q0.pop_front();
        mon_have = 1'b1;
      end else if (phase == 1'b1 && exp_q1.size() != 0) begin
        mon_want = exp_q1.pop_front();
        mon_have = 1'b1;
      end
      if (mon_have) begin
        check(phase == 1'b0 ? "sb_ph0" : "sb_ph1", 128'(mon_got), 128'(mon_want));
      end else begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: popped %0h, required no entry", mon_got);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    phase = 1'b0; bcast_phase = 1'b0; bcast_id = '0;
    raw_x = '0; raw_y = '0; raw_z = '0;
    count_valid = 1'b0; bcast_valid = 1'b0; ref_advance = 1'b0;
    cell_ids = {3'd5, 3'd4, 3'd1, 3'd2, 3'd2, 3'd2};

    // Reset state.
    repeat (3) step();
    check("rst_valid", 128'(ref_valid), 128'(0));
    check("rst_exhausted", 128'(ref_exhausted), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_count", 128'(ref_particle_count), 128'(0));
    check("rst_id", 128'(ref_id), 128'(0));
    rst = 1'b0;
    step();
    check("idle_exhausted_count0", 128'(ref_exhausted), 128'(1));

    // Count 5, sweep 1..5 on phase 0: ID5 drops on the full FIFO.
    set_count(5);
    check("t1_count", 128'(ref_particle_count), 128'(5));
    check("t1_exhausted", 128'(ref_exhausted), 128'(0));
    check("t1_valid0", 128'(ref_valid), 128'(0));
    bcast(0, 1, 1'b1, 1'b0);
    check("t1_valid1", 128'(ref_valid), 128'(1));
    check("t1_id1", 128'(ref_id), 128'(1));
    check("t1_x1", 128'(ref_x), 128'({cx(0), rx(0, 1)}));
    for (int i = 2; i <= 5; i++) bcast(0, i, i <= 4, 1'b0);
    check("t1_overflow", 128'(overflow), 128'(1));
    check("t1_head_held", 128'(ref_id), 128'(1));
    drain(4, "t1a");
    check("t1_not_exhausted", 128'(ref_exhausted), 128'(0));
    bcast(0, 5, 1'b1, 1'b0);
    drain(1, "t1b");
    check("t1_exhausted_end", 128'(ref_exhausted), 128'(1));

    // Count 8: first sweep keeps 1..4, second sweep recaptures 5..8.
    set_count(8);
    check("t2_overflow_cleared", 128'(overflow), 128'(0));
    for (int i = 1; i <= 8; i++) bcast(0, i, i <= 4, 1'b0);
    check("t2_overflow", 128'(overflow), 128'(1));
    drain(4, "t2a");
    for (int i = 1; i <= 8; i++) bcast(0, i, i >= 5, 1'b0);
    check("t2_head5", 128'(ref_id), 128'(5));
    drain(4, "t2b");
    check("t2_exhausted", 128'(ref_exhausted), 128'(1));
    check("t2_overflow_sticky", 128'(overflow), 128'(1));

    // Full FIFO with pop and push in the same cycle.
    set_count(8);
    for (int i = 1; i <= 4; i++) bcast(0, i, 1'b1, 1'b0);
    bcast(0, 5, 1'b1, 1'b1);
    check("t3_head2", 128'(ref_id), 128'(2));
    check("t3_no_overflow", 128'(overflow), 128'(0));
    bcast(0, 6, 1'b0, 1'b0);
    check("t3_still_full", 128'(overflow), 128'(1));
    drain(4, "t3");

    // Interleaved phases with the active phase toggling every cycle.
    set_count(3);
    check("t4_overflow_cleared", 128'(overflow), 128'(0));
    for (int i = 1; i <= 3; i++) begin
      phase = 1'b0;
      bcast(0, i, 1'b1, 1'b0);
      phase = 1'b1;
      bcast(1, i, 1'b1, 1'b0);
    end
    phase = 1'b0;
    step();
    check("t4_ph0_id", 128'(ref_id), 128'(1));
    check("t4_ph0_x", 128'(ref_x), 128'({cx(0), rx(0, 1)}));
    drain(3, "t4_ph0");
    check("t4_ph0_exhausted", 128'(ref_exhausted), 128'(1));
    phase = 1'b1;
    step();
    check("t4_ph1_valid", 128'(ref_valid), 128'(1));
    check("t4_ph1_y", 128'(ref_y), 128'({cy(1), ry(1, 1)}));
    check("t4_ph1_z", 128'(ref_z), 128'({cz(1), rz(1, 1)}));
    drain(3, "t4_ph1");
    check("t4_ph1_exhausted", 128'(ref_exhausted), 128'(1));
    check("t4_q1_empty", 128'(exp_q1.size()), 128'(0));

    // New count re-arms exhaustion; a count word also flushes queued entries.
    phase = 1'b0;
    set_count(2);
    check("t5_exhausted", 128'(ref_exhausted), 128'(0));
    check("t5_count", 128'(ref_particle_count), 128'(2));
    bcast(0, 1, 1'b1, 1'b0);
    check("t5_valid", 128'(ref_valid), 128'(1));
    set_count(2);
    check("t5_flushed", 128'(ref_valid), 128'(0));
    bcast(0, 1, 1'b1, 1'b0);
    check("t5_recapture", 128'(ref_id), 128'(1));
    drain(1, "t5");

    // Asynchronous reset mid-sweep with two entries queued.
    set_count(5);
    bcast(0, 1, 1'b1, 1'b0);
    bcast(0, 2, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_q0.delete();
    check("t6_rst_valid", 128'(ref_valid), 128'(0));
    check("t6_rst_id", 128'(ref_id), 128'(0));
    check("t6_rst_x", 128'(ref_x), 128'(0));
    check("t6_rst_count", 128'(ref_particle_count), 128'(0));
    step();
    rst = 1'b0;
    step();
    check("t6_idle_exhausted", 128'(ref_exhausted), 128'(1));
    set_count(3);
    bcast(0, 2, 1'b0, 1'b0);
    check("t6_id2_ignored", 128'(ref_valid), 128'(0));
    for (int i = 1; i <= 3; i++) bcast(0, i, 1'b1, 1'b0);
    drain(3, "t6");
    check("t6_q0_empty", 128'(exp_q0.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
